instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pipe_reg.sv | 35 +++
 rtl/instr_fetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction
// field positions, default PC width and the fetch state encoding.
package cpu_pkg;

    localparam int PC_W_DEF = 4;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int SRC_HI = 2;
    localparam int SRC_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_reg.sv
// Single-entry valid/ready output register with flush. A flush always wins
// over a load or a drain, so a redirected entry can never leak out.
module pipe_reg #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RESET_DATA;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && !flush) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and decode: walks the PC through instruction memory,
// splits each word into op/rd/src fields and hands it out on valid/ready.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [7:0]      instr,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      dec_op,
    output logic [2:0]      dec_rd,
    output logic [2:0]      dec_src,
    output logic [PC_W-1:0] dec_pc,
    output logic            halted
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
    localparam int              DATA_W = 2 + 3 + 3 + PC_W;

    state_t            state;
    state_t            state_next;
    logic              slot_free;
    logic              capture;
    logic              flush;
    logic              restart;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;

    assign slot_free = !out_valid || out_ready;
    assign in_data   = {instr[OP_HI:OP_LO], instr[RD_HI:RD_LO], instr[SRC_HI:SRC_LO], pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect suppresses the capture, so a HALT under redirect is never seen.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  if (capture && instr[OP_HI:OP_LO] == OP_HALT) state_next = ST_HALTED;
            ST_HALTED: if (restart) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        flush   = 1'b0;
        restart = 1'b0;
        halted  = 1'b0;
        unique case (state)
            ST_FETCH: begin
                flush   = redirect_valid;
                capture = !redirect_valid && slot_free;
            end
            ST_HALTED: begin
                halted  = !out_valid;
                restart = start && !out_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RST_PC;
        end else if (flush) begin
            pc <= redirect_pc;
        end else if (capture) begin
            pc <= pc + PC_W'(1);
        end else if (restart) begin
            pc <= RST_PC;
        end
    end

    pipe_reg #(
        .DATA_W     (DATA_W),
        .RESET_DATA ({8'b0, RST_PC})
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (capture),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    assign {dec_op, dec_rd, dec_src, dec_pc} = out_data;

endmodule
